// File: rtl/fbcpu_pkg.sv
// fbcpu shared definitions: RAM geometry defaults,
// arbiter state encoding and requester port indices.
package fbcpu_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 10;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CMD  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker with host lock override.
// Purely combinational; the caller owns the last-granted pointer.
module arb_rr2
    import fbcpu_pkg::*;
(
    input  logic c_req,
    input  logic h_req,
    input  logic lock,
    input  logic last,
    output logic valid,
    output logic pick
);

    always_comb begin
        valid = c_req | h_req;
        pick  = PORT_CPU;
        if (h_req && lock) begin
            pick = PORT_HOST;
        end else if (h_req && c_req) begin
            // Tie goes to whoever was not served last.
            pick = (last == PORT_CPU) ? PORT_HOST : PORT_CPU;
        end else if (h_req) begin
            pick = PORT_HOST;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// CPU/host arbiter for a single-port synchronous RAM.
// One command every three cycles: IDLE samples, CMD issues, RESP returns.
module ram_arbiter
    import fbcpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    input  logic              h_lock,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_t state;
    arb_state_t state_next;
    logic       owner;
    logic       last;
    logic       is_read;
    logic       pick_valid;
    logic       pick;
    logic       sel_we;

    arb_rr2 u_pick (
        .c_req (c_req),
        .h_req (h_req),
        .lock  (h_lock),
        .last  (last),
        .valid (pick_valid),
        .pick  (pick)
    );

    assign sel_we = (pick == PORT_HOST) ? h_we : c_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= PORT_CPU;
            last      <= PORT_CPU;
            is_read   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else if (state == ARB_IDLE && pick_valid) begin
            owner   <= pick;
            last    <= pick;
            is_read <= ~sel_we;
            ram_we  <= sel_we;
            if (pick == PORT_HOST) begin
                ram_addr  <= h_addr;
                ram_wdata <= h_wdata;
            end else begin
                ram_addr  <= c_addr;
                ram_wdata <= c_wdata;
            end
        end else if (state == ARB_CMD) begin
            // Address and data hold; only the strobe drops.
            ram_we <= 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        c_gnt      = 1'b0;
        h_gnt      = 1'b0;
        c_rvalid   = 1'b0;
        h_rvalid   = 1'b0;
        rdata      = '0;
        unique case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_next = ARB_CMD;
                end
            end
            ARB_CMD: begin
                state_next = ARB_RESP;
                c_gnt      = (owner == PORT_CPU);
                h_gnt      = (owner == PORT_HOST);
            end
            ARB_RESP: begin
                state_next = ARB_IDLE;
                if (is_read) begin
                    rdata    = ram_rdata;
                    c_rvalid = (owner == PORT_CPU);
                    h_rvalid = (owner == PORT_HOST);
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level arbitration model.
module tb_ram_arbiter;

    localparam int AW = 6;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          c_req = 1'b0;
    logic          c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic          c_gnt;
    logic          c_rvalid;
    logic          h_req = 1'b0;
    logic          h_we = 1'b0;
    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_wdata = '0;
    logic          h_lock = 1'b0;
    logic          h_gnt;
    logic          h_rvalid;
    logic [DW-1:0] rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_gnt     (c_gnt),
        .c_rvalid  (c_rvalid),
        .h_req     (h_req),
        .h_we      (h_we),
        .h_addr    (h_addr),
        .h_wdata   (h_wdata),
        .h_lock    (h_lock),
        .h_gnt     (h_gnt),
        .h_rvalid  (h_rvalid),
        .rdata     (rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 50) return DW'(5);
        return DW'((i * 37 + 3) % 1024);
    endfunction

    // Synchronous RAM: registered read, write on ram_we.
    logic [DW-1:0] mem [64];
    bit mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: per-cycle expectation slots, filled when a grant is decided.
    logic [DW-1:0] mmem [64];
    bit            e_cg[4], e_hg[4], e_cr[4], e_hr[4], e_we[4];
    logic [AW-1:0] e_addr[4];
    logic [DW-1:0] e_wd[4], e_rd[4];
    bit            armed = 1'b0;
    bit            last_h = 1'b0;
    int            free_at = 1 << 30;

    initial begin : compare
        int s, g, r;
        bit host, we;
        logic [AW-1:0] a;
        logic [DW-1:0] w;
        for (int i = 0; i < 64; i++) mmem[i] = init_val(i);
        for (int i = 0; i < 4; i++) begin
            e_cg[i] = 0; e_hg[i] = 0; e_cr[i] = 0; e_hr[i] = 0; e_we[i] = 0;
        end
        forever begin
            @(negedge clk);
            s = cyc % 4;
            if (armed) begin
                chk("c_gnt", c_gnt, e_cg[s]);
                chk("h_gnt", h_gnt, e_hg[s]);
                chk("c_rvalid", c_rvalid, e_cr[s]);
                chk("h_rvalid", h_rvalid, e_hr[s]);
                chk("gnt_excl", c_gnt & h_gnt, 0);
                chk("rvalid_excl", c_rvalid & h_rvalid, 0);
                chk("we_only_cmd", ram_we & ~(c_gnt | h_gnt), 0);
                if (e_cg[s] | e_hg[s]) begin
                    chk("ram_we", ram_we, e_we[s]);
                    chk("ram_addr", ram_addr, e_addr[s]);
                    if (e_we[s]) chk("ram_wdata", ram_wdata, e_wd[s]);
                end else begin
                    chk("ram_we_idle", ram_we, 0);
                end
                if (e_cr[s] | e_hr[s]) chk("rdata", rdata, e_rd[s]);
            end
            e_cg[s] = 0; e_hg[s] = 0; e_cr[s] = 0; e_hr[s] = 0; e_we[s] = 0;
            g = (cyc + 1) % 4;
            r = (cyc + 2) % 4;
            if (rst) begin
                e_cg[g] = 0; e_hg[g] = 0; e_cr[g] = 0; e_hr[g] = 0; e_we[g] = 0;
                e_cr[r] = 0; e_hr[r] = 0;
                last_h  = 0;
                free_at = cyc + 2;
                armed   = 1;
            end else if (cyc + 1 >= free_at && (c_req || h_req)) begin
                if (h_req && h_lock) host = 1;
                else if (h_req && c_req) host = !last_h;
                else host = h_req;
                last_h = host;
                we = host ? h_we : c_we;
                a  = host ? h_addr : c_addr;
                w  = host ? h_wdata : c_wdata;
                e_cg[g] = !host; e_hg[g] = host;
                e_we[g] = we; e_addr[g] = a; e_wd[g] = w;
                if (we) begin
                    mmem[a] = w;
                end else begin
                    e_cr[r] = !host; e_hr[r] = host; e_rd[r] = mmem[a];
                end
                free_at = cyc + 4;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output bit host, output bit ok);
        ok = 0;
        host = 0;
        for (int i = 0; i < 12 && !ok; i++) begin
            step();
            if (c_gnt || h_gnt) begin
                ok = 1;
                host = h_gnt;
            end
        end
        if (!ok) chk("gnt_timeout", 0, 1);
    endtask

    task automatic rnd_c();
        c_we    = $urandom_range(0, 1) == 0;
        c_addr  = AW'($urandom_range(0, 15));
        c_wdata = DW'($urandom_range(0, 1023));
    endtask

    task automatic rnd_h();
        h_we    = $urandom_range(0, 1) == 0;
        h_addr  = AW'($urandom_range(0, 15));
        h_wdata = DW'($urandom_range(0, 1023));
    endtask

    initial begin : stim
        bit host, ok;
        int n;
        int gk[4];
        bit gh[4];
        repeat (3) step();
        chk("rst_c_gnt", c_gnt, 0);
        chk("rst_h_gnt", h_gnt, 0);
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_h_rvalid", h_rvalid, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_rdata", rdata, 0);
        rst = 0;
        step();

        c_req = 1; c_we = 0; c_addr = 50;
        step();
        chk("rd50_gnt", c_gnt, 1);
        chk("rd50_addr", ram_addr, 50);
        c_req = 0;
        step();
        chk("rd50_rvalid", c_rvalid, 1);
        chk("rd50_rdata", rdata, 5);
        step();

        h_req = 1; h_we = 1; h_addr = 52; h_wdata = 15;
        step();
        chk("wr52_gnt", h_gnt, 1);
        chk("wr52_we", ram_we, 1);
        chk("wr52_wdata", ram_wdata, 15);
        h_req = 0;
        step();
        chk("wr52_no_rvalid", h_rvalid, 0);
        step();
        c_req = 1; c_we = 0; c_addr = 52;
        step();
        chk("rd52_gnt", c_gnt, 1);
        c_req = 0;
        step();
        chk("rd52_rvalid", c_rvalid, 1);
        chk("rd52_rdata", rdata, 15);
        step();

        c_req = 1; c_we = 0; c_addr = AW'($urandom_range(0, 63));
        h_req = 1; h_we = 0; h_addr = AW'($urandom_range(0, 63));
        rst = 1;
        step();
        step();
        rst = 0;
        n = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (c_gnt || h_gnt) begin
                if (n < 4) begin
                    gk[n] = k;
                    gh[n] = h_gnt;
                end
                n++;
            end
        end
        chk("alt_count", n, 4);
        for (int i = 0; i < 4; i++) begin
            chk("alt_cycle", gk[i], 1 + 3 * i);
            chk("alt_port", gh[i], (i % 2 == 0));
        end

        h_lock = 1;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(host, ok);
            chk("lock_host", host, 1);
        end
        h_lock = 0;
        wait_gnt(host, ok);
        chk("unlock_cpu", host, 0);

        c_req = 0;
        h_we = 1; h_addr = 10; h_wdata = 10'h3FF;
        wait_gnt(host, ok);
        chk("rstwr_host", host, 1);
        chk("rstwr_we", ram_we, 1);
        rst = 1;
        h_req = 0;
        step();
        chk("rstwr_mem10", mem[10], 10'h3FF);
        chk("rstwr_h_rvalid", h_rvalid, 0);
        chk("rstwr_h_gnt", h_gnt, 0);
        chk("rstwr_ram_we", ram_we, 0);
        chk("rstwr_ram_addr", ram_addr, 0);
        chk("rstwr_ram_wdata", ram_wdata, 0);
        chk("rstwr_rdata", rdata, 0);
        rst = 0;
        c_req = 1; c_we = 0; c_addr = 10;
        step();
        chk("rstwr_idle_gnt", c_gnt, 1);
        c_req = 0;
        step();
        chk("rstwr_rd_rvalid", c_rvalid, 1);
        chk("rstwr_rd_rdata", rdata, 10'h3FF);

        for (int k = 0; k < 3000; k++) begin
            step();
            rst = $urandom_range(0, 249) == 0;
            if (c_gnt) begin
                c_req = $urandom_range(0, 2) == 0;
                rnd_c();
            end else if (!c_req && $urandom_range(0, 2) == 0) begin
                c_req = 1;
                rnd_c();
            end
            if (h_gnt) begin
                h_req = $urandom_range(0, 2) == 0;
                rnd_h();
            end else if (!h_req && $urandom_range(0, 2) == 0) begin
                h_req = 1;
                rnd_h();
            end
            h_lock = $urandom_range(0, 5) == 0;
        end
        rst = 0; c_req = 0; h_req = 0; h_lock = 0;
        repeat (5) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6: RAM address width.
REQ-002 Parameter DATA_W, default 10: RAM data width.
REQ-003 clk  in  1: clock; all state updates on rising edge.
REQ-004 rst  in  1: reset, synchronous, active-high.
REQ-005 c_req  in  1: CPU request; held high until c_gnt seen.
REQ-006 c_we  in  1: CPU write (1) / read (0), valid with c_req.
REQ-007 c_addr  in  ADDR_W: CPU address, valid with c_req.
REQ-008 c_wdata  in  DATA_W: CPU write data, valid with c_req.
REQ-009 c_gnt  out  1: CPU command issued this cycle.
REQ-010 c_rvalid  out  1: CPU read data valid on rdata.
REQ-011 h_req, h_we, h_addr, h_wdata  in  1/1/ADDR_W/DATA_W: host (loader/debug) port, same meaning as CPU port.
REQ-012 h_lock  in  1: host priority override, honoured only with h_req high.
REQ-013 h_gnt, h_rvalid  out  1/1: host equivalents of c_gnt, c_rvalid.
REQ-014 rdata  out  DATA_W: read data shared by both ports, qualified by the rvalid flags.
REQ-015 ram_we  out  1: registered RAM write enable.
REQ-016 ram_addr  out  ADDR_W: registered RAM address.
REQ-017 ram_wdata  out  DATA_W: registered RAM write data.
REQ-018 ram_rdata  in  DATA_W: RAM output, registered by RAM, valid the cycle after the address edge.

Function
REQ-019 FSM states: IDLE, CMD, RESP; one transaction per 3 cycles max.
REQ-020 IDLE, no req: stay IDLE, ram_we=0, ram_addr/ram_wdata hold.
REQ-021 IDLE, any req sampled at edge: latch winner's we/addr/wdata into ram_*, set owner, go CMD.
REQ-022 Arbitration: h_req&h_lock -> host; else only one req -> that port; both -> port not granted last (round-robin).
REQ-023 Last-granted pointer updates on every IDLE->CMD transition, including lock grants.
REQ-024 CMD: owner's gnt=1 for exactly one cycle; ram_* driven; next state RESP.
REQ-025 RESP: ram_we=0; if command was a read, owner's rvalid=1 and rdata=ram_rdata; next state IDLE.
REQ-026 Writes produce no rvalid; gnt is the sole write acknowledge.
REQ-027 Requests are sampled only in IDLE; req levels during CMD/RESP are ignored.
REQ-028 Requester deasserts req no later than the RESP cycle; req still high in IDLE is a new request.
REQ-029 Latency: req high at edge N -> gnt high cycle N+1 -> RAM samples edge N+1 -> rvalid high cycle N+2.
REQ-030 c_gnt and h_gnt never high in the same cycle; likewise c_rvalid and h_rvalid.
REQ-031 Continuous h_lock with h_req starves the CPU indefinitely; this is intended for program load.
REQ-032 Address is passed unmodified; no wrap or range check.

Reset
REQ-033 rst high at an edge: state=IDLE; gnt, rvalid, ram_we=0; ram_addr, ram_wdata, rdata=0; pointer=CPU, so host wins the first tie.
REQ-034 rst asserted during CMD: the already-registered command still reaches the RAM at that edge; no rvalid follows.
REQ-035 Requests held through reset deassertion are arbitrated from the first IDLE cycle after reset.

Structure
REQ-036 The shared package fbcpu_pkg SHALL hold ADDR_W/DATA_W defaults, the arbiter state encoding and port index constants (PORT_CPU=0, PORT_HOST=1).
REQ-037 One sub-module, arb_rr2: combinational 2-way round-robin picker with lock input; FSM and registers stay in ram_arbiter.

Verification
REQ-038 CPU read only: c_req, c_we=0, c_addr=50, mem[50]=5 -> c_gnt cycle N+1, c_rvalid and rdata=5 cycle N+2.
REQ-039 Host write then CPU read: h write addr 52 data 15, then c read 52 -> h_gnt, no h_rvalid; c read returns 15.
REQ-040 Both req held continuously after reset -> grants alternate H,C,H,C at 3-cycle spacing.
REQ-041 h_lock=1 with both req held for 4 grants -> 4 consecutive h_gnt, c_gnt 0; drop lock -> next grant CPU.
REQ-042 rst asserted during CMD of a host write of 0x3FF to addr 10 -> mem[10]=0x3FF; no rvalid; outputs zero next cycle; FSM IDLE.
REQ-043 All tests: assert mutual exclusion of gnt and of rvalid, and ram_we high only in CMD.
